// File: rtl/pll_mon_pkg.sv
// Shared state encoding, loss-counter width and range helper for the PLL lock monitor.
package pll_mon_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    MEASURE   = 2'd2,
    RUN       = 2'd3
  } state_t;

  localparam int LOSS_W = 8;

  function automatic logic in_range(input logic [31:0] cnt,
                                    input logic [31:0] lo,
                                    input logic [31:0] hi);
    return (cnt >= lo) && (cnt <= hi);
  endfunction

endpackage

// File: rtl/pll_mon_sync.sv
// Multi-flop synchroniser for asynchronous single-bit inputs; clears to 0 on reset.
module pll_mon_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff_r;

  // shift chain, oldest sample at the top
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ff_r <= '0;
    else     ff_r <= {ff_r[STAGES-2:0], d};
  end

  assign q = ff_r[STAGES-1];

endmodule

// File: rtl/pll_lock_monitor.sv
// Qualifies PLL lock (debounce) and optionally output frequency before releasing downstream reset.
// Frequency check is built only when PLL_MON_FREQ_EN is defined.
module pll_lock_monitor
  import pll_mon_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 1024,
  parameter int GATE_CYCLES   = 25000,
  parameter int CNT_W         = 16,
  parameter int EXP_MIN       = 4750,
  parameter int EXP_MAX       = 5250
) (
  input  logic              CLKI,
  input  logic              RST,
  input  logic              LOCK_I,
  input  logic              TOG_I,
  input  logic              CLR_I,
  output logic              SYS_RST_O,
  output logic              LOCKED_O,
  output logic [CNT_W-1:0]  FREQ_CNT_O,
  output logic              FREQ_VLD_O,
  output logic              FREQ_OK_O,
  output logic [LOSS_W-1:0] LOSS_CNT_O
);

  localparam int STAB_W = $clog2(STABLE_CYCLES + 1);
`ifdef PLL_MON_FREQ_EN
  localparam state_t AFTER_STABLE = MEASURE;
`else
  localparam state_t AFTER_STABLE = RUN;
`endif

  state_t            state_r, next_state_s;
  logic              lock_s;
  logic [STAB_W-1:0] stable_cnt_r;
  logic              stable_done_s;
  logic              win_end_s, win_ok_s;
  logic              loss_evt_s, sys_rst_nxt_s, locked_nxt_s;

  pll_mon_sync #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .clk(CLKI), .rst(RST), .d(LOCK_I), .q(lock_s)
  );

  assign stable_done_s = (stable_cnt_r == STAB_W'(STABLE_CYCLES - 1));

  // state register
  always_ff @(posedge CLKI or posedge RST) begin
    if (RST) state_r <= WAIT_LOCK;
    else     state_r <= next_state_s;
  end

  // next-state logic; lock loss overrides any window result
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      WAIT_LOCK: begin
        if (lock_s) next_state_s = STABLE;
        else        next_state_s = WAIT_LOCK;
      end
      STABLE: begin
        if (!lock_s)            next_state_s = WAIT_LOCK;
        else if (stable_done_s) next_state_s = AFTER_STABLE;
        else                    next_state_s = STABLE;
      end
      MEASURE: begin
        if (!lock_s)                   next_state_s = WAIT_LOCK;
        else if (win_end_s && win_ok_s) next_state_s = RUN;
        else                           next_state_s = MEASURE;
      end
      RUN: begin
        if (!lock_s)                    next_state_s = WAIT_LOCK;
        else if (win_end_s && !win_ok_s) next_state_s = MEASURE;
        else                            next_state_s = RUN;
      end
      default: next_state_s = WAIT_LOCK;
    endcase
  end

  // output decode from the transition about to happen
  always_comb begin
    loss_evt_s    = (state_r == RUN) && (next_state_s != RUN);
    sys_rst_nxt_s = (next_state_s != RUN);
    locked_nxt_s  = (next_state_s == MEASURE) || (next_state_s == RUN);
  end

  // registered status outputs and debounce counter
  always_ff @(posedge CLKI or posedge RST) begin
    if (RST) begin
      SYS_RST_O    <= 1'b1;
      LOCKED_O     <= 1'b0;
      stable_cnt_r <= '0;
    end else begin
      SYS_RST_O <= sys_rst_nxt_s;
      LOCKED_O  <= locked_nxt_s;
      if (state_r == STABLE && lock_s) stable_cnt_r <= stable_cnt_r + STAB_W'(1);
      else                             stable_cnt_r <= '0;
    end
  end

  // saturating loss counter; clear and event together leaves exactly one event
  always_ff @(posedge CLKI or posedge RST) begin
    if (RST)                                    LOSS_CNT_O <= '0;
    else if (CLR_I && loss_evt_s)               LOSS_CNT_O <= LOSS_W'(1);
    else if (CLR_I)                             LOSS_CNT_O <= '0;
    else if (loss_evt_s && (LOSS_CNT_O != '1))  LOSS_CNT_O <= LOSS_CNT_O + LOSS_W'(1);
    else                                        LOSS_CNT_O <= LOSS_CNT_O;
  end

`ifdef PLL_MON_FREQ_EN
  localparam int GATE_W = $clog2(GATE_CYCLES);

  logic              tog_s, tog_prev_r, edge_s, measuring_s;
  logic [GATE_W-1:0] gate_cnt_r;
  logic [CNT_W-1:0]  edge_cnt_r, edge_sum_s;

  pll_mon_sync #(.STAGES(SYNC_STAGES)) u_tog_sync (
    .clk(CLKI), .rst(RST), .d(TOG_I), .q(tog_s)
  );

  assign edge_s      = tog_s ^ tog_prev_r;
  assign measuring_s = (state_r == MEASURE) || (state_r == RUN);
  assign win_end_s   = measuring_s && (gate_cnt_r == GATE_W'(GATE_CYCLES - 1));
  // include the edge landing on the current cycle, saturating at all-ones
  assign edge_sum_s  = (edge_s && (edge_cnt_r != '1)) ? edge_cnt_r + CNT_W'(1) : edge_cnt_r;
  assign win_ok_s    = in_range(32'(edge_sum_s), EXP_MIN, EXP_MAX);

  // gate window, edge counter and published result; lock loss aborts silently
  always_ff @(posedge CLKI or posedge RST) begin
    if (RST) begin
      tog_prev_r <= 1'b0;
      gate_cnt_r <= '0;
      edge_cnt_r <= '0;
      FREQ_CNT_O <= '0;
      FREQ_VLD_O <= 1'b0;
      FREQ_OK_O  <= 1'b0;
    end else begin
      tog_prev_r <= tog_s;
      FREQ_VLD_O <= 1'b0;
      if (measuring_s && lock_s) begin
        if (win_end_s) begin
          gate_cnt_r <= '0;
          edge_cnt_r <= '0;
          FREQ_CNT_O <= edge_sum_s;
          FREQ_VLD_O <= 1'b1;
          FREQ_OK_O  <= win_ok_s;
        end else begin
          gate_cnt_r <= gate_cnt_r + GATE_W'(1);
          edge_cnt_r <= edge_sum_s;
        end
      end else begin
        gate_cnt_r <= '0;
        edge_cnt_r <= '0;
      end
    end
  end
`else
  logic unused_s;

  assign unused_s   = TOG_I ^ ((GATE_CYCLES + EXP_MIN + EXP_MAX) > 0);
  assign win_end_s  = 1'b0;
  assign win_ok_s   = 1'b1;
  assign FREQ_CNT_O = '0;
  assign FREQ_VLD_O = 1'b0;
  assign FREQ_OK_O  = 1'b1;
`endif

endmodule

// File: tb/tb_pll_lock_monitor.sv
// Directed bench for pll_lock_monitor with small timing parameters; follows PLL_MON_FREQ_EN.
`timescale 1ns/1ps
module tb_pll_lock_monitor;

  logic        CLKI = 1'b0;
  logic        RST, LOCK_I, TOG_I, CLR_I;
  logic        SYS_RST_O, LOCKED_O, FREQ_VLD_O, FREQ_OK_O;
  logic [15:0] FREQ_CNT_O;
  logic [7:0]  LOSS_CNT_O;

  int total = 0;
  int bad   = 0;
  int tog_half = 2;
  int tog_cnt  = 0;
  int loss_model = 0;

`ifdef PLL_MON_FREQ_EN
  localparam int   REL_DLY = 116;
  localparam logic OK_RST  = 1'b0;
`else
  localparam int   REL_DLY = 16;
  localparam logic OK_RST  = 1'b1;
`endif

  pll_lock_monitor #(
    .SYNC_STAGES(2), .STABLE_CYCLES(16), .GATE_CYCLES(100),
    .CNT_W(16), .EXP_MIN(45), .EXP_MAX(55)
  ) dut (
    .CLKI(CLKI), .RST(RST), .LOCK_I(LOCK_I), .TOG_I(TOG_I), .CLR_I(CLR_I),
    .SYS_RST_O(SYS_RST_O), .LOCKED_O(LOCKED_O), .FREQ_CNT_O(FREQ_CNT_O),
    .FREQ_VLD_O(FREQ_VLD_O), .FREQ_OK_O(FREQ_OK_O), .LOSS_CNT_O(LOSS_CNT_O)
  );

  always #5 CLKI = ~CLKI;

  // divided-clock stand-in: flips every tog_half cycles
  initial begin
    TOG_I = 1'b0;
    forever begin
      @(negedge CLKI);
      if (tog_half > 0) begin
        tog_cnt++;
        if (tog_cnt >= tog_half) begin
          TOG_I   = ~TOG_I;
          tog_cnt = 0;
        end
      end
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge CLKI);
  endtask

  task automatic check_reset_vals(input string tag);
    check_val({tag, "_sysrst"}, SYS_RST_O, 1);
    check_val({tag, "_locked"}, LOCKED_O, 0);
    check_val({tag, "_fcnt"}, FREQ_CNT_O, 0);
    check_val({tag, "_vld"}, FREQ_VLD_O, 0);
    check_val({tag, "_ok"}, FREQ_OK_O, OK_RST);
    check_val({tag, "_loss"}, LOSS_CNT_O, 0);
  endtask

  // hold reset two cycles, release on a falling edge (cycle 0 reference)
  task automatic do_reset();
    RST = 1'b1;
    #1;
    check_reset_vals("rst");
    step(2);
    RST = 1'b0;
    loss_model = 0;
  endtask

  // one-cycle LOCK_I drop from RUN, checks latency, loss count and re-release
  task automatic glitch(input logic clr_with_evt);
    LOCK_I = 1'b0;
    step(1);
    LOCK_I = 1'b1;
    step(1);
    check_val("drop_hold", SYS_RST_O, 0);
    CLR_I = clr_with_evt;
    step(1);
    CLR_I = 1'b0;
    if (clr_with_evt) loss_model = 1;
    else if (loss_model < 255) loss_model++;
    check_val("drop_sysrst", SYS_RST_O, 1);
    check_val("drop_locked", LOCKED_O, 0);
    check_val("drop_loss", LOSS_CNT_O, loss_model);
    step(REL_DLY);
    check_val("rel_before", SYS_RST_O, 1);
    step(1);
    check_val("rel_after", SYS_RST_O, 0);
  endtask

  initial begin
    RST = 1'b0; LOCK_I = 1'b1; CLR_I = 1'b0;
    #1;
    // 1: lock from reset, release timing
    do_reset();
    step(18);
    check_val("lock_c18", LOCKED_O, 0);
    check_val("sysrst_c18", SYS_RST_O, 1);
    step(1);
    check_val("lock_c19", LOCKED_O, 1);
`ifdef PLL_MON_FREQ_EN
    check_val("sysrst_c19", SYS_RST_O, 1);
    step(99);
    check_val("sysrst_c118", SYS_RST_O, 1);
    check_val("vld_c118", FREQ_VLD_O, 0);
    step(1);
    check_val("sysrst_c119", SYS_RST_O, 0);
    check_val("fcnt_c119", FREQ_CNT_O, 50);
    check_val("ok_c119", FREQ_OK_O, 1);
    check_val("vld_c119", FREQ_VLD_O, 1);
    step(1);
    check_val("vld_c120", FREQ_VLD_O, 0);
`else
    check_val("sysrst_c19", SYS_RST_O, 0);
    check_val("ok_const", FREQ_OK_O, 1);
    check_val("fcnt_const", FREQ_CNT_O, 0);
    check_val("vld_const", FREQ_VLD_O, 0);
`endif
    // 2: single lock glitch
    glitch(1'b0);
`ifdef PLL_MON_FREQ_EN
    // 4: slow clock while running, then restore
    tog_half = 4;
    step(99);
    check_val("slow_hold", SYS_RST_O, 0);
    step(1);
    loss_model++;
    check_val("slow_sysrst", SYS_RST_O, 1);
    check_val("slow_ok", FREQ_OK_O, 0);
    check_val("slow_vld", FREQ_VLD_O, 1);
    check_val("slow_loss", LOSS_CNT_O, loss_model);
    check_val("slow_locked", LOCKED_O, 1);
    tog_half = 2;
    step(99);
    check_val("restore_hold", SYS_RST_O, 1);
    step(1);
    check_val("restore_sysrst", SYS_RST_O, 0);
    check_val("restore_ok", FREQ_OK_O, 1);
`endif
    // 5: saturation, clear, clear coincident with event
    for (int i = 0; i < 300; i++) glitch(1'b0);
    check_val("loss_sat", LOSS_CNT_O, 255);
    CLR_I = 1'b1;
    step(1);
    CLR_I = 1'b0;
    loss_model = 0;
    check_val("loss_clr", LOSS_CNT_O, 0);
    glitch(1'b1);
    check_val("loss_clr_evt", LOSS_CNT_O, 1);
`ifdef PLL_MON_FREQ_EN
    // 3: permanently slow clock never releases
    tog_half = 4;
    do_reset();
    step(19);
    check_val("slow3_locked", LOCKED_O, 1);
    step(100);
    check_val("slow3_vld1", FREQ_VLD_O, 1);
    check_val("slow3_fcnt", FREQ_CNT_O, 25);
    check_val("slow3_ok", FREQ_OK_O, 0);
    check_val("slow3_sysrst", SYS_RST_O, 1);
    step(99);
    check_val("slow3_vld_gap", FREQ_VLD_O, 0);
    step(1);
    check_val("slow3_vld2", FREQ_VLD_O, 1);
    check_val("slow3_loss", LOSS_CNT_O, 0);
    check_val("slow3_sysrst2", SYS_RST_O, 1);
    step(50);
`else
    step(30);
`endif
    // 6: asynchronous reset mid-operation
    #2;
    RST = 1'b1;
    #1;
    check_reset_vals("midrst");
    step(1);
    RST = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
